dmem_dump_arbiter: RTL and testbench

- Owns the single data-memory port and shares it between two requesters: the pipeline MEM stage and the debug unit's memory-dump engine.
- When idle, it is a transparent pass-through of the MEM-stage request.
- On a debug dump request with the CPU halted, it sequences word reads over the whole data memory. Each word goes to the debug/UART path over a valid/ready handshake.
- Sits between the MEM stage, the debug unit and the byte-addressed data memory (negedge memory, read data updated while write_en=0).

---
 rtl/dmem_dump_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: passes MEM-stage accesses through when idle and
// sequences a word-by-word memory dump to the debug path. Optional macro: DMEM_DUMP_SKIP_ZERO_EN.
module dmem_dump_arbiter #(
  parameter int WORD_LEN      = 32,
  parameter int DATA_MEM_SIZE = 1024,
  parameter int DUMP_WORDS    = DATA_MEM_SIZE / 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cpu_halted,
  input  logic                i_cpu_write_en,
  input  logic [1:0]          i_cpu_size,
  input  logic                i_cpu_unsigned,
  input  logic [WORD_LEN-1:0] i_cpu_addr,
  input  logic [WORD_LEN-1:0] i_cpu_data,
  input  logic [WORD_LEN-1:0] i_mem_data,
  output logic                o_mem_write_en,
  output logic [1:0]          o_mem_size,
  output logic                o_mem_unsigned,
  output logic [WORD_LEN-1:0] o_mem_addr,
  output logic [WORD_LEN-1:0] o_mem_data,
  input  logic                i_dbg_dump_req,
  input  logic                i_dbg_ready,
  output logic                o_dbg_valid,
  output logic [WORD_LEN-1:0] o_dbg_data,
  output logic [WORD_LEN-1:0] o_dbg_addr,
  output logic                o_dbg_done,
  output logic                o_busy
);

  // state      | meaning
  // ST_IDLE    | memory port mirrors the MEM stage; waits for a halted dump request
  // ST_RD_ADDR | word address driven; memory updates read data on the negedge
  // ST_RD_DATA | read data captured into the debug output registers
  // ST_PRESENT | o_dbg_valid high, word held until i_dbg_ready
  // ST_DONE    | one-cycle o_dbg_done pulse, then back to ST_IDLE

  localparam int CNT_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_PRESENT,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic                pend_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dbg_valid_q;
  logic                dbg_done_q;
  logic                busy_q;
  logic [WORD_LEN-1:0] dbg_data_q;
  logic [WORD_LEN-1:0] dbg_addr_q;
  logic [WORD_LEN-1:0] dump_addr;

  assign dump_addr = WORD_LEN'(cnt_q) << 2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      dbg_valid_q <= 1'b0;
      dbg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      dbg_data_q  <= '0;
      dbg_addr_q  <= '0;
    end else begin
      dbg_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((i_dbg_dump_req || pend_q) && i_cpu_halted) begin
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RD_ADDR;
          end else if (i_dbg_dump_req) begin
            pend_q <= 1'b1;
          end
        end
        ST_RD_ADDR: state_q <= ST_RD_DATA;
        ST_RD_DATA:
`ifdef DMEM_DUMP_SKIP_ZERO_EN
          if (i_mem_data == '0) begin
            if (cnt_q == LAST_CNT) begin
              dbg_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_RD_ADDR;
            end
          end else
`endif
          begin
            dbg_data_q  <= i_mem_data;
            dbg_addr_q  <= dump_addr;
            dbg_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end
        ST_PRESENT: begin
          if (i_dbg_ready) begin
            dbg_valid_q <= 1'b0;
            if (cnt_q == LAST_CNT) begin
              dbg_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          dbg_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Outside IDLE the CPU side is cut off, so stores issued during a dump are dropped.
  always_comb begin
    if (state_q == ST_IDLE) begin
      o_mem_write_en = i_cpu_write_en;
      o_mem_size     = i_cpu_size;
      o_mem_unsigned = i_cpu_unsigned;
      o_mem_addr     = i_cpu_addr;
      o_mem_data     = i_cpu_data;
    end else begin
      o_mem_write_en = 1'b0;
      o_mem_size     = 2'b10;
      o_mem_unsigned = 1'b1;
      o_mem_addr     = dump_addr;
      o_mem_data     = '0;
    end
  end

  assign o_dbg_valid = dbg_valid_q;
  assign o_dbg_data  = dbg_data_q;
  assign o_dbg_addr  = dbg_addr_q;
  assign o_dbg_done  = dbg_done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Directed bench for dmem_dump_arbiter on a 16-byte memory; expectations
// switch with DMEM_DUMP_SKIP_ZERO_EN for the zero-word scenario.
module tb_dmem_dump_arbiter;
  localparam int WL = 32;
  localparam int MS = 16;

  logic          i_clk;
  logic          i_rst;
  logic          i_cpu_halted;
  logic          i_cpu_write_en;
  logic [1:0]    i_cpu_size;
  logic          i_cpu_unsigned;
  logic [WL-1:0] i_cpu_addr;
  logic [WL-1:0] i_cpu_data;
  logic [WL-1:0] i_mem_data;
  logic          o_mem_write_en;
  logic [1:0]    o_mem_size;
  logic          o_mem_unsigned;
  logic [WL-1:0] o_mem_addr;
  logic [WL-1:0] o_mem_data;
  logic          i_dbg_dump_req;
  logic          i_dbg_ready;
  logic          o_dbg_valid;
  logic [WL-1:0] o_dbg_data;
  logic [WL-1:0] o_dbg_addr;
  logic          o_dbg_done;
  logic          o_busy;

  dmem_dump_arbiter #(.WORD_LEN(WL), .DATA_MEM_SIZE(MS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpu_halted(i_cpu_halted),
    .i_cpu_write_en(i_cpu_write_en), .i_cpu_size(i_cpu_size),
    .i_cpu_unsigned(i_cpu_unsigned), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .i_mem_data(i_mem_data),
    .o_mem_write_en(o_mem_write_en), .o_mem_size(o_mem_size),
    .o_mem_unsigned(o_mem_unsigned), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .i_dbg_dump_req(i_dbg_dump_req),
    .i_dbg_ready(i_dbg_ready), .o_dbg_valid(o_dbg_valid),
    .o_dbg_data(o_dbg_data), .o_dbg_addr(o_dbg_addr),
    .o_dbg_done(o_dbg_done), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Negedge read-only memory model
  logic [WL-1:0] mem [0:3];
  always @(negedge i_clk) if (!o_mem_write_en) i_mem_data <= mem[o_mem_addr[3:2]];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_dump();
    i_dbg_dump_req = 1'b1;
    tick();
    i_dbg_dump_req = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (o_dbg_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_mem(input logic [WL-1:0] w0, input logic [WL-1:0] w1,
                          input logic [WL-1:0] w2, input logic [WL-1:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_dbg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_dbg_done); end
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o_dbg_data); end
    checks++; if (o_dbg_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", o_dbg_addr); end
  endtask

  task automatic test_passthrough();
    i_cpu_write_en = 1'b1; i_cpu_size = 2'b10; i_cpu_unsigned = 1'b0;
    i_cpu_addr = 32'h10; i_cpu_data = 32'hDEADBEEF;
    #1;
    checks++; if (o_mem_write_en !== 1'b1) begin errors++; $display("FAIL pt_we got %b exp 1", o_mem_write_en); end
    checks++; if (o_mem_size !== 2'b10) begin errors++; $display("FAIL pt_size got %b exp 10", o_mem_size); end
    checks++; if (o_mem_unsigned !== 1'b0) begin errors++; $display("FAIL pt_uns got %b exp 0", o_mem_unsigned); end
    checks++; if (o_mem_addr !== 32'h10) begin errors++; $display("FAIL pt_addr got %h exp 10", o_mem_addr); end
    checks++; if (o_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pt_data got %h exp deadbeef", o_mem_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pt_busy got %b exp 0", o_busy); end
    i_cpu_write_en = 1'b0; i_cpu_size = 2'b00; i_cpu_unsigned = 1'b1; i_cpu_addr = 32'h7;
    #1;
    checks++; if ({o_mem_write_en, o_mem_size, o_mem_unsigned, o_mem_addr} !== {1'b0, 2'b00, 1'b1, 32'h7}) begin
      errors++; $display("FAIL pt_load got %b %b %b %h exp 0 00 1 00000007", o_mem_write_en, o_mem_size, o_mem_unsigned, o_mem_addr);
    end
    tick();
  endtask

  task automatic test_full_dump();
    bit exp_valid, exp_done, exp_busy;
    logic [WL-1:0] exp_addr, exp_data;
    load_mem(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    i_cpu_halted = 1'b1; i_dbg_ready = 1'b1;
    start_dump();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      exp_valid = (cyc % 3 == 0) && (cyc <= 12);
      exp_done  = (cyc == 13);
      exp_busy  = (cyc <= 13);
      checks++; if (o_dbg_valid !== exp_valid) begin errors++; $display("FAIL full_valid c%0d got %b exp %b", cyc, o_dbg_valid, exp_valid); end
      checks++; if (o_dbg_done !== exp_done) begin errors++; $display("FAIL full_done c%0d got %b exp %b", cyc, o_dbg_done, exp_done); end
      checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL full_busy c%0d got %b exp %b", cyc, o_busy, exp_busy); end
      if (exp_valid) begin
        exp_addr = 32'((cyc / 3 - 1) * 4);
        exp_data = mem[cyc / 3 - 1];
        checks++; if (o_dbg_addr !== exp_addr) begin errors++; $display("FAIL full_addr c%0d got %h exp %h", cyc, o_dbg_addr, exp_addr); end
        checks++; if (o_dbg_data !== exp_data) begin errors++; $display("FAIL full_data c%0d got %h exp %h", cyc, o_dbg_data, exp_data); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    i_dbg_ready = 1'b0;
    start_dump();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_dbg_valid !== 1'b1) begin errors++; $display("FAIL bp_valid %0d got %b exp 1", i, o_dbg_valid); end
      checks++; if (o_dbg_addr !== 32'h0) begin errors++; $display("FAIL bp_addr %0d got %h exp 0", i, o_dbg_addr); end
      checks++; if (o_dbg_data !== 32'h11111111) begin errors++; $display("FAIL bp_data %0d got %h exp 11111111", i, o_dbg_data); end
      checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL bp_cnt %0d got %h exp 0", i, o_mem_addr); end
      tick();
    end
    i_dbg_ready = 1'b1;
    tick();
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_mem_addr !== 32'h4) begin errors++; $display("FAIL bp_release_cnt got %h exp 4", o_mem_addr); end
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout exp pulse"); end
    tick();
  endtask

  task automatic test_pending();
    bit ok;
    i_cpu_halted = 1'b0; i_dbg_ready = 1'b1;
    start_dump();
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pend_wait_busy %0d got %b exp 0", i, o_busy); end
      tick();
    end
    i_cpu_halted = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL pend_start_busy got %b exp 1", o_busy); end
    checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL pend_start_addr got %h exp 0", o_mem_addr); end
    // halt drops and a second request arrives mid-dump
    i_cpu_halted = 1'b0;
    start_dump();
    wait_done(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_done got timeout exp pulse"); end
    tick();
    i_cpu_halted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pend_no_queue %0d got %b exp 0", i, o_busy); end
      tick();
    end
  endtask

  task automatic test_cpu_write_during_dump();
    bit ok;
    i_cpu_halted = 1'b1; i_dbg_ready = 1'b1;
    i_cpu_write_en = 1'b1; i_cpu_size = 2'b00; i_cpu_unsigned = 1'b0;
    i_cpu_addr = 32'h0; i_cpu_data = 32'hBAD0BAD0;
    start_dump();
    checks++; if ({o_mem_write_en, o_mem_size, o_mem_unsigned} !== {1'b0, 2'b10, 1'b1}) begin
      errors++; $display("FAIL cw_ctrl got %b %b %b exp 0 10 1", o_mem_write_en, o_mem_size, o_mem_unsigned);
    end
    checks++; if (o_mem_data !== 32'h0) begin errors++; $display("FAIL cw_mdata got %h exp 0", o_mem_data); end
    tick();
    tick();
    checks++; if (o_dbg_valid !== 1'b1) begin errors++; $display("FAIL cw_valid got %b exp 1", o_dbg_valid); end
    checks++; if (o_dbg_data !== 32'h11111111) begin errors++; $display("FAIL cw_data got %h exp 11111111", o_dbg_data); end
    i_cpu_write_en = 1'b0;
    wait_done(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cw_done got timeout exp pulse"); end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    i_cpu_halted = 1'b1; i_dbg_ready = 1'b1;
    start_dump();
    for (int i = 0; i < 20; i++) begin
      if (o_dbg_valid === 1'b1 && o_dbg_addr === 32'h8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach got timeout exp word 2"); end
    i_rst = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", o_busy); end
    checks++; if (o_dbg_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", o_dbg_valid); end
    checks++; if (o_dbg_done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", o_dbg_done); end
    checks++; if (o_dbg_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h exp 0", o_dbg_addr); end
    i_rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++; if (o_dbg_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL rmid_after %0d got done %b busy %b exp 0 0", i, o_dbg_done, o_busy);
      end
      tick();
    end
  endtask

  task automatic test_zero_words();
    int beats = 0;
    int dones = 0;
    logic [WL-1:0] last_addr = '0;
    logic [WL-1:0] last_data = '0;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    int            exp_beats = 1;
    logic [WL-1:0] exp_addr = 32'h4;
    logic [WL-1:0] exp_data = 32'h5;
`else
    int            exp_beats = 4;
    logic [WL-1:0] exp_addr = 32'hC;
    logic [WL-1:0] exp_data = 32'h0;
`endif
    load_mem(32'h0, 32'h5, 32'h0, 32'h0);
    i_cpu_halted = 1'b1; i_dbg_ready = 1'b1;
    start_dump();
    for (int i = 0; i < 20; i++) begin
      if (o_dbg_valid === 1'b1) begin
        beats++;
        last_addr = o_dbg_addr;
        last_data = o_dbg_data;
      end
      if (o_dbg_done === 1'b1) dones++;
      tick();
    end
    checks++; if (beats != exp_beats) begin errors++; $display("FAIL zero_beats got %0d exp %0d", beats, exp_beats); end
    checks++; if (last_addr !== exp_addr) begin errors++; $display("FAIL zero_addr got %h exp %h", last_addr, exp_addr); end
    checks++; if (last_data !== exp_data) begin errors++; $display("FAIL zero_data got %h exp %h", last_data, exp_data); end
    checks++; if (dones != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", dones); end
  endtask

  initial begin
    i_rst = 1'b1; i_cpu_halted = 1'b0; i_cpu_write_en = 1'b0; i_cpu_size = 2'b00;
    i_cpu_unsigned = 1'b0; i_cpu_addr = '0; i_cpu_data = '0;
    i_dbg_dump_req = 1'b0; i_dbg_ready = 1'b0;
    load_mem(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    test_reset();
    test_passthrough();
    test_full_dump();
    test_backpressure();
    test_pending();
    test_cpu_write_during_dump();
    test_reset_mid_dump();
    test_zero_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
